dwa_dac_encoder: RTL and testbench

DWA_DAC_ENCODER -- requirements
Module: dwa_dac_encoder

---
 rtl/dwa_dac_encoder.sv | 102 ++++++++++
 tb/tb_dwa_dac_encoder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dwa_dac_encoder.sv
`default_nettype none
// ============================================================================
// Module      : dwa_dac_encoder
// Description : Unit-element DAC encoder. Turns an unsigned code (count of
//               elements to turn on) into a one-hot-per-element enable vector.
//               It can produce a fixed thermometer code, or use data-weighted
//               averaging (DWA). DWA rotates the selected run of elements
//               around the array using a pointer. An optional LFSR dither adds
//               0 or 1 to the pointer step to break up tonal patterns.
// Ports       : clk       - rising-edge clock
//               rst_n     - asynchronous active-low reset
//               en        - sample strobe
//               mode      - 00 thermometer, 01/11 DWA, 10 DWA + dither
//               code      - number of elements to enable (0..N_EL-1)
//               el_out    - registered unit-element enables
//               ptr_out   - registered rotation pointer
//               valid_out - registered copy of en
// Revision    : 1.0 - initial release
// ============================================================================
module dwa_dac_encoder #(
    parameter int IN_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [IN_W-1:0]       code,
    output logic [(1<<IN_W)-1:0]  el_out,
    output logic [IN_W-1:0]       ptr_out,
    output logic                  valid_out
);

    localparam int N_EL = 2**IN_W;

    localparam logic [1:0]  c_MODE_THERM  = 2'b00;
    localparam logic [1:0]  c_MODE_DITHER = 2'b10;
    localparam logic [15:0] c_LFSR_SEED   = 16'hACE1;

    logic [N_EL-1:0] r_el;
    logic [IN_W-1:0] r_ptr;
    logic            r_valid;
    logic [15:0]     r_lfsr;

    logic            w_is_therm;
    logic            w_is_dither;
    logic            w_dither;
    logic            w_lfsr_fb;
    logic [15:0]     w_lfsr_next;
    logic [IN_W-1:0] w_base;
    logic [IN_W-1:0] w_ptr_next;
    logic [N_EL-1:0] w_el_next;

    assign w_is_therm  = (mode == c_MODE_THERM);
    assign w_is_dither = (mode == c_MODE_DITHER);

    // Fibonacci LFSR, taps 16/14/13/11 expressed as right-shift bit indices
    // 0/2/3/5. The dither bit is the LSB before the shift.
    assign w_lfsr_fb   = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_lfsr_next = {w_lfsr_fb, r_lfsr[15:1]};
    assign w_dither    = w_is_dither & r_lfsr[0];

    // Thermometer mode is a DWA selection anchored at element 0. This makes
    // both modes share a single selection network.
    assign w_base = w_is_therm ? '0 : r_ptr;

    // Pointer arithmetic wraps naturally at IN_W bits (mod N_EL).
    assign w_ptr_next = w_is_therm ? r_ptr
                                   : (r_ptr + code + IN_W'(w_dither));

    // Element j is on when its distance from the base, taken modulo N_EL,
    // is less than code. This gives exactly `code` bits set at any pointer
    // value, including selections that wrap past the top of the array.
    for (genvar gj = 0; gj < N_EL; gj++) begin : g_sel
        logic [IN_W-1:0] w_off;
        assign w_off         = IN_W'(gj) - w_base;
        assign w_el_next[gj] = (w_off < code);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_el    <= '0;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_lfsr  <= c_LFSR_SEED;
        end else begin
            r_valid <= en;
            if (en) begin
                r_el  <= w_el_next;
                r_ptr <= w_ptr_next;
                if (w_is_dither) begin
                    r_lfsr <= w_lfsr_next;
                end
            end
        end
    end

    assign el_out    = r_el;
    assign ptr_out   = r_ptr;
    assign valid_out = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dwa_dac_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dwa_dac_encoder
// Description : Self-checking bench for dwa_dac_encoder (IN_W=4). A
//               behavioural model predicts each registered output when the
//               stimulus is applied. The prediction is queued, then popped and
//               compared after the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dwa_dac_encoder;

    localparam int IN_W = 4;
    localparam int N_EL = 16;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic [1:0]      mode;
    logic [IN_W-1:0] code;
    logic [N_EL-1:0] el_out;
    logic [IN_W-1:0] ptr_out;
    logic            valid_out;

    dwa_dac_encoder #(.IN_W(IN_W)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .code      (code),
        .el_out    (el_out),
        .ptr_out   (ptr_out),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_EL-1:0] el;
        logic [IN_W-1:0] ptr;
        logic            valid;
        logic [IN_W-1:0] code;
    } exp_t;

    exp_t q_exp[$];

    // Reference model state
    logic [N_EL-1:0] m_el;
    logic [IN_W-1:0] m_ptr;
    logic [15:0]     m_lfsr;

    int n_checks;
    int n_errors;
    int use_cnt[N_EL];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_el   = '0;
        m_ptr  = '0;
        m_lfsr = 16'hACE1;
        q_exp.delete();
    endtask

    // Apply one sample, predict its result, then compare it after the edge.
    task automatic step(input logic e, input logic [1:0] md, input logic [IN_W-1:0] cd);
        exp_t x;
        int   base;
        int   dith;
        logic fb;
        if (e) begin
            base = (md == 2'b00) ? 0 : int'(m_ptr);
            m_el = '0;
            for (int i = 0; i < int'(cd); i++) m_el[(base + i) % N_EL] = 1'b1;
            dith = (md == 2'b10) ? int'(m_lfsr[0]) : 0;
            if (md != 2'b00) m_ptr = IN_W'((int'(m_ptr) + int'(cd) + dith) % N_EL);
            if (md == 2'b10) begin
                fb     = m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5];
                m_lfsr = {fb, m_lfsr[15:1]};
            end
        end
        x.el    = m_el;
        x.ptr   = m_ptr;
        x.valid = e;
        x.code  = cd;
        q_exp.push_back(x);
        en   = e;
        mode = md;
        code = cd;
        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            x = q_exp.pop_front();
            check("el_out", el_out, x.el);
            check("ptr_out", ptr_out, x.ptr);
            check("valid_out", valid_out, x.valid);
            if (x.valid) check("popcount", $countones(el_out), x.code);
        end
    endtask

    // Assert reset between clock edges and confirm the clear happens at once.
    task automatic async_reset();
        rst_n = 1'b0;
        #1;
        check("rst_el", el_out, 0);
        check("rst_ptr", ptr_out, 0);
        check("rst_valid", valid_out, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int mn;
        int mx;
        n_checks = 0;
        n_errors = 0;
        en   = 1'b0;
        mode = 2'b01;
        code = '0;
        rst_n = 1'b1;
        #2;
        async_reset();

        // DWA sequence and wrap
        step(1'b1, 2'b01, 4'd5);
        check("dwa0_el", el_out, 16'h001F); check("dwa0_ptr", ptr_out, 5);
        step(1'b1, 2'b01, 4'd5);
        check("dwa1_el", el_out, 16'h03E0); check("dwa1_ptr", ptr_out, 10);
        step(1'b1, 2'b01, 4'd5);
        check("dwa2_el", el_out, 16'h7C00); check("dwa2_ptr", ptr_out, 15);
        step(1'b1, 2'b01, 4'd3);
        check("wrap_el", el_out, 16'h8003); check("wrap_ptr", ptr_out, 2);

        // Thermometer leaves the pointer alone
        step(1'b1, 2'b00, 4'd7);
        check("therm0_el", el_out, 16'h007F); check("therm0_ptr", ptr_out, 2);
        step(1'b1, 2'b00, 4'd7);
        check("therm1_el", el_out, 16'h007F); check("therm1_ptr", ptr_out, 2);

        // Hold with en low
        step(1'b1, 2'b01, 4'd4);
        check("pre_hold_el", el_out, 16'h003C);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'b01, 4'd9);
            check("hold_el", el_out, 16'h003C);
            check("hold_ptr", ptr_out, 6);
            check("hold_valid", valid_out, 0);
        end

        // Code zero, then dither mode and mode 11
        step(1'b1, 2'b01, 4'd0);
        check("zero_el", el_out, 0);
        step(1'b1, 2'b10, 4'd0);
        step(1'b1, 2'b11, 4'd15);
        step(1'b1, 2'b10, 4'd9);

        // Reset in the middle of the stream, away from the edge
        #2;
        async_reset();
        step(1'b1, 2'b01, 4'd1);
        check("post_rst_el", el_out, 16'h0001);

        // Random DWA from a fresh reset; track usage spread
        async_reset();
        for (int i = 0; i < N_EL; i++) use_cnt[i] = 0;
        for (int n = 0; n < 5000; n++) begin
            step(($urandom_range(0, 9) != 0), 2'b01, IN_W'($urandom_range(0, N_EL - 1)));
            if (valid_out) begin
                for (int i = 0; i < N_EL; i++) use_cnt[i] += int'(el_out[i]);
                mn = use_cnt[0];
                mx = use_cnt[0];
                for (int i = 1; i < N_EL; i++) begin
                    if (use_cnt[i] < mn) mn = use_cnt[i];
                    if (use_cnt[i] > mx) mx = use_cnt[i];
                end
                check("usage_spread_le1", (mx - mn <= 1), 1);
            end
        end

        // Random dithered DWA: pointer follows the reference LFSR model
        for (int n = 0; n < 5000; n++) begin
            step(($urandom_range(0, 9) != 0), 2'b10, IN_W'($urandom_range(0, N_EL - 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
